board_mem_io_bridge: RTL and testbench

//  Board-side data-bus bridge between cpu_main's load/store port and on-board resources.

---
 rtl/board_mem_io_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_board_mem_io_bridge.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_io_bridge.sv
// board_mem_io_bridge
//   Board-side bridge between the CPU load/store port and on-board resources.
//   Each CPU access is decoded to synchronous block RAM (with RAM_WAIT extra
//   access cycles), one of GPIO_CH 16-bit GPIO channels, or a bus error.
//   Every accepted access finishes with a single-cycle cpu_ready pulse.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   cpu_addr/cpu_wdata  byte address and store data (latched at access start)
//   cpu_we/cpu_re       store/load strobes, held until cpu_ready
//   cpu_rdata           load data, valid while cpu_ready=1 (zero-extended)
//   cpu_ready           one-cycle completion pulse
//   ram_en/ram_we       RAM strobes, asserted for the whole ACCESS phase
//   ram_addr/ram_wdata  RAM word address and write data
//   ram_rdata           RAM read data, valid the cycle after an enabled edge
//   gpio_in             asynchronous board inputs (2-flop synchronised)
//   gpio_out            registered board outputs
//   bus_err/err_clear   sticky access-error flag and its clear

module board_mem_io_bridge #(
  parameter int          XLEN     = 32,
  parameter int          MEM_AW   = 12,
  parameter int          RAM_WAIT = 1,
  parameter int          GPIO_CH  = 2,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       cpu_addr,
  input  logic [XLEN-1:0]       cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [XLEN-1:0]       cpu_rdata,
  output logic                  cpu_ready,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [MEM_AW-1:0]     ram_addr,
  output logic [XLEN-1:0]       ram_wdata,
  input  logic [XLEN-1:0]       ram_rdata,
  input  logic [16*GPIO_CH-1:0] gpio_in,
  output logic [16*GPIO_CH-1:0] gpio_out,
  output logic                  bus_err,
  input  logic                  err_clear
);

  localparam int              GW        = 16 * GPIO_CH;
  localparam int              KW        = $clog2(2 * GPIO_CH);
  localparam logic [XLEN-1:0] IO_BASE_X = XLEN'(IO_BASE);
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(64'd1 << (MEM_AW + 2));
  localparam logic [XLEN-1:0] IO_SPAN   = XLEN'(8 * GPIO_CH);
  localparam logic [2:0]      WAIT_INIT = 3'(RAM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_IO,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              op_we_q;
  logic [MEM_AW-1:0] word_q;
  logic [XLEN-1:0]   wdata_q;
  logic [KW-1:0]     k_q;
  logic [2:0]        wait_q;
  logic [XLEN-1:0]   rdata_q;
  logic              bus_err_q;
  logic [GW-1:0]     gpio_out_q;
  logic [GW-1:0]     gpio_sync1;
  logic [GW-1:0]     gpio_sync2;
  logic [15:0]       gpio_rd;

  logic [XLEN-1:0] io_off;
  logic [KW-1:0]   io_k;
  logic            ram_hit;
  logic            io_hit;
  logic            io_ro;
  logic            dec_err;
  logic            start;

  // Address decode on the live bus; only used in the start cycle, after which
  // the latched copies drive everything. Upper address bits take part in both
  // window compares, so aliases above the RAM window fall through to error.
  assign io_off  = cpu_addr - IO_BASE_X;
  assign ram_hit = cpu_addr < RAM_LIMIT;
  assign io_hit  = (cpu_addr >= IO_BASE_X) && (io_off < IO_SPAN);
  assign io_k    = io_off[KW+1:2];
  assign io_ro   = io_k >= KW'(GPIO_CH);
  assign dec_err = (cpu_we & cpu_re) | (cpu_addr[1:0] != 2'b00) |
                   ~(ram_hit | io_hit) | (cpu_we & io_hit & io_ro);
  assign start   = (state_q == S_IDLE) & (cpu_we | cpu_re);

  assign cpu_rdata = rdata_q;
  assign ram_addr  = word_q;
  assign ram_wdata = wdata_q;
  assign gpio_out  = gpio_out_q;
  assign bus_err   = bus_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes. Errors skip straight to DONE so they never touch
  // RAM or GPIO; DONE ignores strobes so a held strobe is only seen again in
  // the following IDLE cycle.
  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    cpu_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we | cpu_re) begin
          if (dec_err) begin
            state_d = S_DONE;
          end else if (ram_hit) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_IO;
          end
        end
      end
      S_ACCESS: begin
        ram_en = 1'b1;
        ram_we = op_we_q;
        if (wait_q == 3'd0) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_IO:      state_d = S_DONE;
      S_DONE: begin
        cpu_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word-offset mux over output channels (read-back) followed by the
  // synchronised input channels.
  always_comb begin
    gpio_rd = '0;
    for (int c = 0; c < GPIO_CH; c++) begin
      if (k_q == KW'(c)) begin
        gpio_rd = gpio_out_q[c*16 +: 16];
      end
      if (k_q == KW'(c + GPIO_CH)) begin
        gpio_rd = gpio_sync2[c*16 +: 16];
      end
    end
  end

  // Access datapath: latch the request at start, count RAM wait states,
  // capture RAM data or perform the GPIO read/write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_we_q    <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
    end else begin
      if (start) begin
        op_we_q <= cpu_we;
        word_q  <= cpu_addr[MEM_AW+1:2];
        wdata_q <= cpu_wdata;
        k_q     <= io_k;
        wait_q  <= WAIT_INIT;
        if (dec_err) begin
          rdata_q <= '0;
        end
      end
      case (state_q)
        S_ACCESS: begin
          if (wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
          end
        end
        S_CAPTURE: rdata_q <= op_we_q ? '0 : ram_rdata;
        S_IO: begin
          if (op_we_q) begin
            rdata_q <= '0;
            for (int c = 0; c < GPIO_CH; c++) begin
              if (k_q == KW'(c)) begin
                gpio_out_q[c*16 +: 16] <= wdata_q[15:0];
              end
            end
          end else begin
            rdata_q <= XLEN'(gpio_rd);
          end
        end
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
    end else if (start && dec_err) begin
      bus_err_q <= 1'b1;
    end else if (err_clear) begin
      bus_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_board_mem_io_bridge.sv
// Testbench for board_mem_io_bridge: main instance with default parameters,
// plus RAM_WAIT=0 and RAM_WAIT=7 instances used for latency checks.

module tb_board_mem_io_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, gpio_in;
  logic        cpu_we, cpu_re, err_clear;
  logic        we_w0, re_w0, we_w7, re_w7;

  logic [31:0] cpu_rdata, ram_wdata, ram_rdata, gpio_out;
  logic        cpu_ready, ram_en, ram_we, bus_err;
  logic [11:0] ram_addr;

  logic [31:0] rdata_w0, ram_wdata_w0, ram_rdata_w0, gpio_out_w0;
  logic        ready_w0, ram_en_w0, ram_we_w0, bus_err_w0;
  logic [11:0] ram_addr_w0;
  logic [31:0] rdata_w7, ram_wdata_w7, ram_rdata_w7, gpio_out_w7;
  logic        ready_w7, ram_en_w7, ram_we_w7, bus_err_w7;
  logic [11:0] ram_addr_w7;

  board_mem_io_bridge dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .bus_err(bus_err), .err_clear(err_clear));

  board_mem_io_bridge #(.RAM_WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(we_w0), .cpu_re(re_w0), .cpu_rdata(rdata_w0), .cpu_ready(ready_w0),
    .ram_en(ram_en_w0), .ram_we(ram_we_w0), .ram_addr(ram_addr_w0), .ram_wdata(ram_wdata_w0),
    .ram_rdata(ram_rdata_w0), .gpio_in(gpio_in), .gpio_out(gpio_out_w0),
    .bus_err(bus_err_w0), .err_clear(err_clear));

  board_mem_io_bridge #(.RAM_WAIT(7)) dut_w7 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(we_w7), .cpu_re(re_w7), .cpu_rdata(rdata_w7), .cpu_ready(ready_w7),
    .ram_en(ram_en_w7), .ram_we(ram_we_w7), .ram_addr(ram_addr_w7), .ram_wdata(ram_wdata_w7),
    .ram_rdata(ram_rdata_w7), .gpio_in(gpio_in), .gpio_out(gpio_out_w7),
    .bus_err(bus_err_w7), .err_clear(err_clear));

  // Synchronous block RAM models: read data valid the cycle after an enabled edge.
  logic [31:0] mem_m [4096];
  logic [31:0] mem_0 [4096];
  logic [31:0] mem_7 [4096];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem_m[ram_addr] <= ram_wdata;
      ram_rdata <= mem_m[ram_addr];
    end
  end
  always @(posedge clk) begin
    if (ram_en_w0) begin
      if (ram_we_w0) mem_0[ram_addr_w0] <= ram_wdata_w0;
      ram_rdata_w0 <= mem_0[ram_addr_w0];
    end
  end
  always @(posedge clk) begin
    if (ram_en_w7) begin
      if (ram_we_w7) mem_7[ram_addr_w7] <= ram_wdata_w7;
      ram_rdata_w7 <= mem_7[ram_addr_w7];
    end
  end

  // Scoreboard of expected responses.
  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] gpio_model   = 32'h0;

  // Drives one access on the main instance and reports what was observed:
  // latency in cycles from the start cycle, response, RAM strobe counts.
  // The live address/data are scrambled after the start cycle.
  task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                            output logic err, output logic to, output int en_cnt,
                            output int we_cnt, output logic [11:0] first_addr,
                            output logic [31:0] gpio_rdy);
    lat = 0; rd = '0; err = 1'b0; to = 1'b1; en_cnt = 0; we_cnt = 0;
    first_addr = '0; gpio_rdy = '0;
    @(negedge clk);
    cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_re = re;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ram_en) begin
        if (en_cnt == 0) first_addr = ram_addr;
        en_cnt++;
      end
      if (ram_we) we_cnt++;
      if (cpu_ready) begin
        lat = i; rd = cpu_rdata; err = bus_err; gpio_rdy = gpio_out; to = 1'b0;
        break;
      end
      cpu_addr = ~addr; cpu_wdata = ~wdata;
    end
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic clear_err;
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({cpu_ready, ram_en, ram_we, bus_err} !== 4'b0 || cpu_rdata !== 32'h0 || gpio_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: ready=%b ram_en=%b ram_we=%b bus_err=%b rdata=%h gpio_out=%h, required all 0",
               cpu_ready, ram_en, ram_we, bus_err, cpu_rdata, gpio_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    logic [31:0] addrs [2] = '{32'h0000_0010, 32'h0000_3FFC};
    logic [31:0] datas [2] = '{32'hDEAD_BEEF, 32'h600D_CAFE};
    logic [11:0] words [2] = '{12'h004, 12'hFFF};
    for (int n = 0; n < 2; n++) begin
      sb.push_back('{32'h0, 4, 1'b0});
      run_access(1'b1, 1'b0, addrs[n], datas[n], lat, rd, err, to, en, wc, fa, gp);
      e = sb.pop_front();
      tests_run++;
      if (to || lat !== e.lat || rd !== e.rdata || err !== e.err) begin
        tests_failed++;
        $display("[TB] FAIL ram_store[%0d]: lat=%0d rdata=%h err=%b timeout=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, to, e.lat, e.rdata, e.err);
      end
      tests_run++;
      if (en !== 2 || wc !== 2 || fa !== words[n]) begin
        tests_failed++;
        $display("[TB] FAIL ram_store_strobes[%0d]: en=%0d we=%0d addr=%h, required en=2 we=2 addr=%h",
                 n, en, wc, fa, words[n]);
      end
      sb.push_back('{datas[n], 4, 1'b0});
      run_access(1'b0, 1'b1, addrs[n], 32'h0, lat, rd, err, to, en, wc, fa, gp);
      e = sb.pop_front();
      tests_run++;
      if (to || lat !== e.lat || rd !== e.rdata || err !== e.err) begin
        tests_failed++;
        $display("[TB] FAIL ram_load[%0d]: lat=%0d rdata=%h err=%b timeout=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, to, e.lat, e.rdata, e.err);
      end
      tests_run++;
      if (en !== 2 || wc !== 0 || fa !== words[n]) begin
        tests_failed++;
        $display("[TB] FAIL ram_load_strobes[%0d]: en=%0d we=%0d addr=%h, required en=2 we=0 addr=%h",
                 n, en, wc, fa, words[n]);
      end
    end
  endtask

  task automatic test_gpio_out;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    logic [31:0] addrs [3] = '{32'hFFFF_0004, 32'hFFFF_0004, 32'hFFFF_0000};
    logic [31:0] datas [3] = '{32'hABCD_1234, 32'h0, 32'h9999_5555};
    logic        is_st [3] = '{1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 3; n++) begin
      if (is_st[n]) begin
        if (addrs[n][2]) gpio_model[31:16] = datas[n][15:0];
        else             gpio_model[15:0]  = datas[n][15:0];
        sb.push_back('{32'h0, 2, 1'b0});
      end else begin
        sb.push_back('{{16'h0, addrs[n][2] ? gpio_model[31:16] : gpio_model[15:0]}, 2, 1'b0});
      end
      run_access(is_st[n], !is_st[n], addrs[n], datas[n], lat, rd, err, to, en, wc, fa, gp);
      e = sb.pop_front();
      tests_run++;
      if (to || lat !== e.lat || rd !== e.rdata || err !== e.err) begin
        tests_failed++;
        $display("[TB] FAIL gpio_out_access[%0d]: lat=%0d rdata=%h err=%b timeout=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, to, e.lat, e.rdata, e.err);
      end
      tests_run++;
      if (gp !== gpio_model || en !== 0) begin
        tests_failed++;
        $display("[TB] FAIL gpio_out_value[%0d]: gpio_out=%h ram_en_cycles=%0d, required gpio_out=%h ram_en_cycles=0",
                 n, gp, en, gpio_model);
      end
    end
  endtask

  task automatic test_gpio_in;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    @(negedge clk);
    gpio_in = 32'h3C3C_A5A5;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      sb.push_back('{(n == 0) ? 32'h0000_A5A5 : 32'h0000_3C3C, 2, 1'b0});
      run_access(1'b0, 1'b1, (n == 0) ? 32'hFFFF_0008 : 32'hFFFF_000C, 32'h0,
                 lat, rd, err, to, en, wc, fa, gp);
      e = sb.pop_front();
      tests_run++;
      if (to || lat !== e.lat || rd !== e.rdata || err !== e.err) begin
        tests_failed++;
        $display("[TB] FAIL gpio_in_load[%0d]: lat=%0d rdata=%h err=%b timeout=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, to, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_bus_err;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    sb.push_back('{32'h0, 1, 1'b1});
    run_access(1'b0, 1'b1, 32'h0000_4000, 32'h0, lat, rd, err, to, en, wc, fa, gp);
    e = sb.pop_front();
    tests_run++;
    if (to || lat !== e.lat || rd !== e.rdata || err !== e.err || en !== 0) begin
      tests_failed++;
      $display("[TB] FAIL err_unmapped: lat=%0d rdata=%h err=%b timeout=%b ram_en_cycles=%0d, required lat=%0d rdata=%h err=%b ram_en_cycles=0",
               lat, rd, err, to, en, e.lat, e.rdata, e.err);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: bus_err=%b, required 1", bus_err);
    end
    clear_err();
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clear: bus_err=%b, required 0", bus_err);
    end
    // Error start cycle coincides with err_clear: the set must win.
    sb.push_back('{32'h0, 1, 1'b1});
    @(negedge clk);
    cpu_addr = 32'h0000_4000; cpu_re = 1'b1; err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== e.rdata || bus_err !== e.err) begin
      tests_failed++;
      $display("[TB] FAIL err_set_wins: ready=%b rdata=%h bus_err=%b, required ready=1 rdata=%h bus_err=%b",
               cpu_ready, cpu_rdata, bus_err, e.rdata, e.err);
    end
    cpu_re = 1'b0;
    clear_err();
  endtask

  task automatic test_decode_errors;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    logic        t_we   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_re   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_addr [5] = '{32'h0000_0012, 32'hFFFF_0008, 32'h0000_0010,
                                32'hFFFF_0010, 32'hFFFE_FFFC};
    for (int n = 0; n < 5; n++) begin
      clear_err();
      sb.push_back('{32'h0, 1, 1'b1});
      run_access(t_we[n], t_re[n], t_addr[n], 32'h7777_7777, lat, rd, err, to, en, wc, fa, gp);
      e = sb.pop_front();
      tests_run++;
      if (to || lat !== e.lat || rd !== e.rdata || err !== e.err) begin
        tests_failed++;
        $display("[TB] FAIL decode_err[%0d]: lat=%0d rdata=%h err=%b timeout=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, to, e.lat, e.rdata, e.err);
      end
      tests_run++;
      if (en !== 0 || gp !== gpio_model) begin
        tests_failed++;
        $display("[TB] FAIL decode_err_side[%0d]: ram_en_cycles=%0d gpio_out=%h, required ram_en_cycles=0 gpio_out=%h",
                 n, en, gp, gpio_model);
      end
    end
    clear_err();
  endtask

  task automatic test_reset_mid_access;
    exp_t e; int lat, en, wc; logic [31:0] rd, gp; logic err, to; logic [11:0] fa;
    logic saw_ready;
    @(negedge clk);
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0BAD_0BAD; cpu_we = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ram_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_in_access: ram_en=%b, required 1", ram_en);
    end
    rst = 1'b0;
    #1;
    gpio_model = 32'h0;
    tests_run++;
    if (ram_en !== 1'b0 || cpu_ready !== 1'b0 || gpio_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: ram_en=%b ready=%b gpio_out=%h, required 0 0 00000000",
               ram_en, cpu_ready, gpio_out);
    end
    cpu_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    saw_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ready) saw_ready = 1'b1;
    end
    tests_run++;
    if (saw_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_ready: ready seen=%b, required 0", saw_ready);
    end
    sb.push_back('{32'hDEAD_BEEF, 4, 1'b0});
    run_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, lat, rd, err, to, en, wc, fa, gp);
    e = sb.pop_front();
    tests_run++;
    if (to || lat !== e.lat || rd !== e.rdata || err !== e.err || gp !== gpio_model) begin
      tests_failed++;
      $display("[TB] FAIL abort_ram_intact: lat=%0d rdata=%h err=%b timeout=%b gpio_out=%h, required lat=%0d rdata=%h err=%b gpio_out=%h",
               lat, rd, err, to, gp, e.lat, e.rdata, e.err, gpio_model);
    end
  endtask

  task automatic test_wait_latency;
    exp_t e0, e7; int lat0, lat7; logic [31:0] rd0, rd7; logic done0, done7;
    for (int op = 0; op < 2; op++) begin
      sb.push_back('{(op == 0) ? 32'h0 : 32'hCAFE_F00D, 3, 1'b0});
      sb.push_back('{(op == 0) ? 32'h0 : 32'hCAFE_F00D, 10, 1'b0});
      @(negedge clk);
      cpu_addr = 32'h0000_0020; cpu_wdata = 32'hCAFE_F00D;
      we_w0 = (op == 0); re_w0 = (op == 1); we_w7 = (op == 0); re_w7 = (op == 1);
      lat0 = 0; lat7 = 0; rd0 = '0; rd7 = '0; done0 = 1'b0; done7 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (!done0 && ready_w0) begin
          done0 = 1'b1; lat0 = i; rd0 = rdata_w0; we_w0 = 1'b0; re_w0 = 1'b0;
        end
        if (!done7 && ready_w7) begin
          done7 = 1'b1; lat7 = i; rd7 = rdata_w7; we_w7 = 1'b0; re_w7 = 1'b0;
        end
        if (done0 && done7) break;
      end
      we_w0 = 1'b0; re_w0 = 1'b0; we_w7 = 1'b0; re_w7 = 1'b0;
      e0 = sb.pop_front();
      e7 = sb.pop_front();
      tests_run++;
      if (!done0 || lat0 !== e0.lat || rd0 !== e0.rdata) begin
        tests_failed++;
        $display("[TB] FAIL wait0_op%0d: done=%b lat=%0d rdata=%h, required lat=%0d rdata=%h",
                 op, done0, lat0, rd0, e0.lat, e0.rdata);
      end
      tests_run++;
      if (!done7 || lat7 !== e7.lat || rd7 !== e7.rdata) begin
        tests_failed++;
        $display("[TB] FAIL wait7_op%0d: done=%b lat=%0d rdata=%h, required lat=%0d rdata=%h",
                 op, done7, lat7, rd7, e7.lat, e7.rdata);
      end
    end
    tests_run++;
    if ({bus_err_w0, bus_err_w7} !== 2'b00 || gpio_out_w0 !== 32'h0 || gpio_out_w7 !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL wait_side: bus_err=%b%b gpio_out=%h/%h, required 0 and 0",
               bus_err_w0, bus_err_w7, gpio_out_w0, gpio_out_w7);
    end
  endtask

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    we_w0 = 1'b0; re_w0 = 1'b0; we_w7 = 1'b0; re_w7 = 1'b0;
    gpio_in = '0; err_clear = 1'b0;
    test_reset();
    test_ram();
    test_gpio_out();
    test_gpio_in();
    test_bus_err();
    test_decode_errors();
    test_reset_mid_access();
    test_wait_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
